rng_scheduler: RTL and testbench
================================

Name: rng_scheduler

Overview:
- Sequences and shares the 16-bit XNOR LFSR random source between several requesters.
- After reset or on a reseed request, it fetches the seed from memory at SEED_ADDR, substitutes a safe value if the seed is the lockup state, then serves draws.
- Requesters are served round-robin. The LFSR steps only on a granted draw, so every consumer gets a distinct value.
- Sits between the memory read port and the game-logic blocks that consume random numbers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SEED_ADDR, 16'h07FE, memory address holding RNG_SEED
MEM_LAT, 1, cycles from address valid to mem_data_out valid (>=1)
DEFAULT_SEED, 16'h0005, reset LFSR value and substitute for lockup seed 16'hFFFF

Ports:
clock  input  1  system clock, rising edge
nreset  input  1  asynchronous active-low reset
mem_data_out  input  16  memory read data
address  output  16  memory read address; SEED_ADDR in load states, 16'h0000 otherwise
mem_rd  output  1  read strobe; decoded from state
req  input  NUM_REQ  per-requester draw request, level, held until granted
reseed  input  1  single-cycle pulse, reload seed from memory
gnt  output  NUM_REQ  one-hot grant, registered, 1-cycle pulse per draw
rnd_valid  output  1  registered; equals |gnt
rnd_data  output  16  registered LFSR value delivered with gnt
rnd_4bit  output  4  rnd_data[3:0]
busy  output  1  high while not in RUN

Behaviour:
- Reset: one clock named clock; reset is asynchronous and active-low, named nreset.
  - Asserting nreset low at any time, including mid-load or mid-draw, immediately sets: state=INIT, lfsr=DEFAULT_SEED, gnt=0, rnd_valid=0, rnd_data=0, rr pointer=NUM_REQ-1, busy=1, mem_rd=0, address=0.
- LFSR step: next = {lfsr[14:0], ~(lfsr[15]^lfsr[14]^lfsr[12]^lfsr[3])}.
- States and transitions:
  - INIT: mem_rd=0. Next edge goes to LOAD_ADDR.
  - LOAD_ADDR: address=SEED_ADDR, mem_rd=1. Lasts 1 cycle, then LOAD_WAIT.
  - LOAD_WAIT: address=SEED_ADDR, mem_rd=1. Lasts MEM_LAT cycles.
    - At the edge ending the last LOAD_WAIT cycle: lfsr<=mem_data_out, or DEFAULT_SEED if mem_data_out==16'hFFFF. State goes to RUN.
  - RUN: busy=0, mem_rd=0.
    - Each cycle with |req and no reseed: grant the first asserted req searching upward from pointer+1 (modulo NUM_REQ).
    - At the edge: gnt<=onehot(winner), rnd_data<=lfsr (pre-step value), rnd_valid<=1, lfsr<=next, pointer<=winner.
    - Cycles with no req: gnt=0, rnd_valid=0, lfsr holds, rnd_data holds its last value.
- Latency:
  - Reset release to RUN: 3 edges with MEM_LAT=1 (INIT, LOAD_ADDR, LOAD_WAIT); busy falls after the 3rd edge.
  - req sampled in RUN produces gnt at the next edge.
  - Full throughput is one draw per cycle.
- Handshake:
  - Draws are granted from combinational req; a requester seeing gnt=1 takes rnd_data that same cycle.
  - If req stays high, it continues to be granted, subject to round-robin. Deassert req in the gnt cycle for a single draw.
  - A lone requester is granted back-to-back every cycle.
- Boundary conditions:
  - reseed in RUN has priority over req that cycle: no grant, next state INIT→LOAD_ADDR path skipped, goes directly to LOAD_ADDR. gnt=0 while loading. Pending reqs wait until RUN.
  - reseed outside RUN is ignored.
  - Pointer wrap: after granting NUM_REQ-1, the search starts at 0.
  - Lockup seed 16'hFFFF is never loaded into lfsr.
  - lfsr never advances except on a grant.

Test Plan:
- mem[0x7FE]=16'h1234, nreset released, req=0 -> busy high for 3 cycles, then 0; mem_rd high exactly 2 cycles; address=16'h07FE during those cycles.
- Seed 0x1234, req=4'b1111 held -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; rnd_data 1234,2468,48D0,91A0,...; rnd_4bit 4,8,0,0.
- Seed 16'hFFFF, req=4'b0100 pulse then again -> rnd_data 0005 then 000B; gnt 0100 each time.
- In RUN, req=4'b0011 held and reseed pulsed same cycle, mem now 16'h1234 -> no gnt for that cycle plus load cycles; busy high 2 cycles; first grant afterwards delivers 1234 to the requester after the last-granted one.
- nreset pulled low mid-LOAD_WAIT and mid-grant stream -> outputs reset immediately without a clock edge; reload restarts from INIT; pointer restarts, so req0 wins first.
- Single requester req=4'b1000 held 4 cycles, seed 0x1234 -> gnt=1000 every cycle; data 1234,2468,48D0,91A0.

Source files
------------

// File: rtl/rng_scheduler.sv
// rng_scheduler: loads a seed from memory and shares one 16-bit XNOR LFSR
// between NUM_REQ requesters. Requesters are served round-robin, and the
// LFSR steps only on a granted draw, so each draw gets a distinct value.
//
// Ports:
//   clock, nreset   rising-edge clock, asynchronous active-low reset
//   mem_data_out    memory read data, valid MEM_LAT cycles after address
//   address, mem_rd memory read port; SEED_ADDR and mem_rd=1 while loading
//   req, reseed     level draw requests; single-cycle reseed pulse (RUN only)
//   gnt, rnd_valid  registered one-hot grant and its valid (|gnt)
//   rnd_data        LFSR value delivered with gnt; rnd_4bit = rnd_data[3:0]
//   busy            high while not in RUN
module rng_scheduler #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] SEED_ADDR    = 16'h07FE,
  parameter int          MEM_LAT      = 1,
  parameter logic [15:0] DEFAULT_SEED = 16'h0005
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [15:0]        mem_data_out,
  output logic [15:0]        address,
  output logic               mem_rd,
  input  logic [NUM_REQ-1:0] req,
  input  logic               reseed,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  output logic [3:0]         rnd_4bit,
  output logic               busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {INIT, LOAD_ADDR, LOAD_WAIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [15:0]     lfsr, lfsr_nxt;
  logic [PW-1:0]   ptr, win;
  logic [CW-1:0]   wcnt;
  logic            wait_last, found, draw;

  assign lfsr_nxt  = {lfsr[14:0], ~(lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3])};
  assign wait_last = (wcnt == CW'(MEM_LAT - 1));
  // reseed wins over any request in the same RUN cycle
  assign draw      = (state == RUN) && (|req) && !reseed;
  assign rnd_4bit  = rnd_data[3:0];

  // Round-robin search upward from ptr+1, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // state register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= INIT;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:      state_nxt = LOAD_ADDR;
      LOAD_ADDR: state_nxt = LOAD_WAIT;
      LOAD_WAIT: if (wait_last) state_nxt = RUN;
      RUN:       if (reseed) state_nxt = LOAD_ADDR;
      default:   state_nxt = INIT;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    address = 16'h0000;
    mem_rd  = 1'b0;
    busy    = 1'b1;
    case (state)
      LOAD_ADDR, LOAD_WAIT: begin
        address = SEED_ADDR;
        mem_rd  = 1'b1;
      end
      RUN:     busy = 1'b0;
      default: ;
    endcase
  end

  // Counts LOAD_WAIT cycles so the seed is captured when data is valid.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)                 wcnt <= '0;
    else if (state != LOAD_WAIT) wcnt <= '0;
    else                         wcnt <= wcnt + CW'(1);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      lfsr      <= DEFAULT_SEED;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= 16'h0000;
      ptr       <= PW'(NUM_REQ - 1);
    end else begin
      gnt       <= draw ? (ONE << win) : '0;
      rnd_valid <= draw;
      if (state == LOAD_WAIT && wait_last)
        // all-ones is the XNOR lockup state and must never reach lfsr
        lfsr <= (mem_data_out == 16'hFFFF) ? DEFAULT_SEED : mem_data_out;
      else if (draw)
        lfsr <= lfsr_nxt;
      if (draw) begin
        rnd_data <= lfsr;
        ptr      <= win;
      end
    end
  end

endmodule

// File: tb/tb_rng_scheduler.sv
module tb_rng_scheduler;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] mem_data_out = 16'h0;
  logic [15:0] address;
  logic        mem_rd;
  logic [3:0]  req = 4'b0;
  logic        reseed = 1'b0;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic [3:0]  rnd_4bit;
  logic        busy;
  logic [15:0] seed = 16'h1234;

  int n_chk = 0;
  int n_fail = 0;

  rng_scheduler #(.NUM_REQ(4), .SEED_ADDR(16'h07FE), .MEM_LAT(1), .DEFAULT_SEED(16'h0005)) dut (
    .clock(clock), .nreset(nreset), .mem_data_out(mem_data_out),
    .address(address), .mem_rd(mem_rd), .req(req), .reseed(reseed),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_4bit(rnd_4bit), .busy(busy)
  );

  always #5 clock = ~clock;

  // one-cycle-latency memory holding the seed at 0x07FE
  always @(posedge clock) mem_data_out <= (address == 16'h07FE) ? seed : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_draw(input string tag, input logic [3:0] g, input logic [15:0] d);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".data"}, rnd_data, d);
    chk({tag, ".vld"}, rnd_valid, 1'b1);
  endtask

  // issue reseed and step through LOAD_ADDR, LOAD_WAIT into RUN
  task automatic do_reseed(input string tag);
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    chk({tag, ".ld_busy"}, busy, 1'b1);
    chk({tag, ".ld_gnt"}, gnt, 4'b0);
    tick();
    chk({tag, ".wt_busy"}, busy, 1'b1);
    chk({tag, ".wt_gnt"}, gnt, 4'b0);
    tick();
    chk({tag, ".run_busy"}, busy, 1'b0);
  endtask

  logic [15:0] seq [5];
  logic [3:0]  rr  [5];

  initial begin
    seq[0] = 16'h1234; seq[1] = 16'h2468; seq[2] = 16'h48D0;
    seq[3] = 16'h91A0; seq[4] = 16'h2341;
    rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100; rr[3] = 4'b1000; rr[4] = 4'b0001;

    // reset state and load sequence
    #12;
    chk("rst.busy", busy, 1'b1);
    chk("rst.gnt", gnt, 4'b0);
    chk("rst.data", rnd_data, 16'h0);
    chk("rst.vld", rnd_valid, 1'b0);
    chk("rst.mem_rd", mem_rd, 1'b0);
    chk("rst.addr", address, 16'h0);
    nreset = 1'b1;
    tick();
    chk("la.busy", busy, 1'b1);
    chk("la.mem_rd", mem_rd, 1'b1);
    chk("la.addr", address, 16'h07FE);
    tick();
    chk("lw.busy", busy, 1'b1);
    chk("lw.mem_rd", mem_rd, 1'b1);
    chk("lw.addr", address, 16'h07FE);
    tick();
    chk("run.busy", busy, 1'b0);
    chk("run.mem_rd", mem_rd, 1'b0);
    chk("run.addr", address, 16'h0);

    // all four requesting: round-robin with wrap
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_draw($sformatf("rr%0d", i), rr[i], seq[i]);
      if (i < 4) chk($sformatf("rr%0d.4b", i), rnd_4bit, {28'h0, seq[i][3:0]});
    end
    req = 4'b0;
    tick();
    chk("idle.gnt", gnt, 4'b0);
    chk("idle.vld", rnd_valid, 1'b0);
    chk("idle.hold", rnd_data, 16'h2341);

    // reseed has priority over req; req0 was granted last, so req1 wins next
    req = 4'b0011;
    do_reseed("rs");
    chk("rs.run_gnt", gnt, 4'b0);
    tick();
    chk_draw("rs.d0", 4'b0010, 16'h1234);
    tick();
    chk_draw("rs.d1", 4'b0001, 16'h2468);
    req = 4'b0;

    // lockup seed replaced by DEFAULT_SEED; reseed during load is ignored
    seed = 16'hFFFF;
    reseed = 1'b1;
    tick();
    chk("lk.ld_busy", busy, 1'b1);
    tick();
    reseed = 1'b0;
    chk("lk.wt_busy", busy, 1'b1);
    tick();
    chk("lk.run_busy", busy, 1'b0);
    req = 4'b0100;
    tick();
    req = 4'b0;
    chk_draw("lk.d0", 4'b0100, 16'h0005);
    tick();
    chk("lk.gap", gnt, 4'b0);
    req = 4'b0100;
    tick();
    req = 4'b0;
    chk_draw("lk.d1", 4'b0100, 16'h000B);

    // async reset mid LOAD_WAIT
    seed = 16'h1234;
    tick();
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    tick();
    chk("ar1.pre_mem_rd", mem_rd, 1'b1);
    #2 nreset = 1'b0;
    #1;
    chk("ar1.busy", busy, 1'b1);
    chk("ar1.mem_rd", mem_rd, 1'b0);
    chk("ar1.addr", address, 16'h0);
    chk("ar1.data", rnd_data, 16'h0);
    #1 nreset = 1'b1;
    tick(); tick(); tick();
    chk("ar1.run", busy, 1'b0);

    // async reset mid grant stream; pointer restarts so req0 wins first
    req = 4'b1111;
    tick();
    chk_draw("ar2.d0", 4'b0001, 16'h1234);
    tick();
    chk_draw("ar2.d1", 4'b0010, 16'h2468);
    #2 nreset = 1'b0;
    #1;
    chk("ar2.gnt", gnt, 4'b0);
    chk("ar2.vld", rnd_valid, 1'b0);
    chk("ar2.data", rnd_data, 16'h0);
    chk("ar2.busy", busy, 1'b1);
    #1 nreset = 1'b1;
    tick();
    chk("ar2.init_gnt", gnt, 4'b0);
    tick(); tick();
    chk("ar2.run", busy, 1'b0);
    tick();
    chk_draw("ar2.first", 4'b0001, 16'h1234);
    req = 4'b0;

    // lone requester granted back-to-back
    do_reseed("lone");
    req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_draw($sformatf("lone%0d", i), 4'b1000, seq[i]);
    end
    req = 4'b0;
    tick();
    chk("lone.end", gnt, 4'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
